// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: two-requester round-robin front end for a shared ALU.
// A request is latched into ctrl/A/B in IDLE, held for one settle cycle in
// EXEC, and its result is captured from Leds in DONE together with an ack
// pulse to the granted requester. Illegal operations (opcode 5..7, or
// DIV/MOD by zero) return 0 and raise err alongside the ack.
// Optional feature: define ALU_REQ_ARBITER_OPCNT_EN to enable the 8-bit
// wrapping completed-operation counter on op_count; otherwise op_count is 0.
module alu_req_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic [2:0] op0,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  output logic       ack0,
  output logic [5:0] res0,
  input  logic       req1,
  input  logic [2:0] op1,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  output logic       ack1,
  output logic [5:0] res1,
  output logic [2:0] ctrl,
  output logic [2:0] A,
  output logic [2:0] B,
  input  logic [5:0] Leds,
  output logic       busy,
  output logic       err,
  output logic [7:0] op_count
);

  localparam int NUM_REQ = 2;
  localparam int OP_W    = 3;
  localparam int RES_W   = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0] op;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } alu_req_t;

  state_t                         state_q, state_d;
  logic [NUM_REQ-1:0]             req_v;
  alu_req_t [NUM_REQ-1:0]         req_pkt;
  logic                           win;
  logic                           grant_q;
  logic                           last_q;
  logic                           load;
  logic                           commit;
  logic                           illegal;
  logic [RES_W-1:0]               result;
  logic [NUM_REQ-1:0]             ack_v;
  logic [NUM_REQ-1:0][RES_W-1:0]  res_v;

  assign req_v      = {req1, req0};
  assign req_pkt[0] = '{op: op0, a: a0, b: b0};
  assign req_pkt[1] = '{op: op1, a: a1, b: b1};

  // Single request wins outright; on a tie the one not served last wins.
  assign win = (&req_v) ? ~last_q : req_v[1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and per-state strobes
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_v) begin
          load    = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = DONE;
      DONE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

  // Issue registers: snapshot of the winner's request, held until next grant
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl    <= '0;
      A       <= '0;
      B       <= '0;
      grant_q <= 1'b0;
    end else if (load) begin
      ctrl    <= req_pkt[win].op;
      A       <= req_pkt[win].a;
      B       <= req_pkt[win].b;
      grant_q <= win;
    end
  end

  // Legality is judged on the issued snapshot, not on live inputs
  assign illegal = (ctrl > 3'd4) || (((ctrl == 3'd3) || (ctrl == 3'd4)) && (B == 3'd0));
  assign result  = illegal ? '0 : Leds;

  // Last-served pointer; starts at requester 1 so requester 0 wins first tie
  always_ff @(posedge clk) begin
    if (rst)         last_q <= 1'b1;
    else if (commit) last_q <= grant_q;
  end

  // Error pulse coincident with the ack of an illegal operation
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else     err <= commit & illegal;
  end

  // Per-requester ack pulse and held result
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    logic hit;
    assign hit = commit && (grant_q == 1'(g));

    // Only the granted slot moves; the other keeps its ack low and res held
    always_ff @(posedge clk) begin
      if (rst) begin
        ack_v[g] <= 1'b0;
        res_v[g] <= '0;
      end else begin
        ack_v[g] <= hit;
        if (hit) res_v[g] <= result;
      end
    end
  end

  assign ack0 = ack_v[0];
  assign ack1 = ack_v[1];
  assign res0 = res_v[0];
  assign res1 = res_v[1];

`ifdef ALU_REQ_ARBITER_OPCNT_EN
  // Completed-operation counter, bumps on the same edge as every ack
  always_ff @(posedge clk) begin
    if (rst)         op_count <= '0;
    else if (commit) op_count <= op_count + 8'd1;
  end
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: directed and randomized checks of alu_req_arbiter
// against a transaction-level reference model (fixed 3-cycle latency,
// round-robin order, results from plain arithmetic).
module tb_alu_req_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [2:0] op0 = '0, a0 = '0, b0 = '0;
  logic [2:0] op1 = '0, a1 = '0, b1 = '0;
  logic       ack0, ack1, busy, err;
  logic [5:0] res0, res1, Leds;
  logic [2:0] ctrl, A, B;
  logic [7:0] op_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0), .res0(res0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1), .res1(res1),
    .ctrl(ctrl), .A(A), .B(B), .Leds(Leds),
    .busy(busy), .err(err), .op_count(op_count)
  );

  // Shared ALU: junk (0x2A) on illegal ops so forcing to 0 is observable
  function automatic logic [5:0] alu_f(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    logic [5:0] x, y, r;
    x = {3'b0, a};
    y = {3'b0, b};
    case (op)
      3'd0:    r = x + y;
      3'd1:    r = x - y;
      3'd2:    r = x * y;
      3'd3:    r = (b != 3'd0) ? x / y : 6'h2A;
      3'd4:    r = (b != 3'd0) ? x % y : 6'h2A;
      default: r = 6'h2A;
    endcase
    return r;
  endfunction

  assign Leds = alu_f(ctrl, A, B);

  function automatic logic ref_ill(input logic [2:0] op, input logic [2:0] b);
    return (op > 3'd4) || ((op == 3'd3 || op == 3'd4) && b == 3'd0);
  endfunction

  function automatic logic [5:0] ref_res(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b);
    int x, y, r;
    x = int'(a);
    y = int'(b);
    r = 0;
    case (op)
      3'd0: r = x + y;
      3'd1: r = x - y;
      3'd2: r = x * y;
      3'd3: r = (y == 0) ? 0 : x / y;
      3'd4: r = (y == 0) ? 0 : x % y;
      default: r = 0;
    endcase
    if (ref_ill(op, b)) r = 0;
    return r[5:0];
  endfunction

  function automatic logic [8:0] rand_any();
    logic [2:0] op;
    op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    return {op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))};
  endfunction

  function automatic logic [8:0] rand_legal();
    return {3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), 3'($urandom_range(1, 7))};
  endfunction

  // Reference model: a granted job completes exactly 3 cycles after grant
  int         to_ack;
  logic       m_who, m_last, m_err;
  logic [5:0] m_res;
  logic       e_ack0, e_ack1, e_err, e_busy;
  logic [5:0] e_res0, e_res1;
  logic [2:0] e_ctrl, e_A, e_B;
  logic [7:0] e_cnt;
  logic       w_now;

  assign w_now = (req0 && req1) ? !m_last : req1;

  always @(posedge clk) begin
    if (rst) begin
      to_ack <= 0;
      m_who  <= 1'b0;  m_last <= 1'b1;  m_err <= 1'b0;  m_res <= '0;
      e_ack0 <= 1'b0;  e_ack1 <= 1'b0;  e_err <= 1'b0;  e_busy <= 1'b0;
      e_res0 <= '0;    e_res1 <= '0;
      e_ctrl <= '0;    e_A <= '0;       e_B <= '0;      e_cnt <= '0;
    end else begin
      e_ack0 <= 1'b0;
      e_ack1 <= 1'b0;
      e_err  <= 1'b0;
      if (to_ack == 0) begin
        if (req0 || req1) begin
          m_who  <= w_now;
          e_ctrl <= w_now ? op1 : op0;
          e_A    <= w_now ? a1 : a0;
          e_B    <= w_now ? b1 : b0;
          m_res  <= w_now ? ref_res(op1, a1, b1) : ref_res(op0, a0, b0);
          m_err  <= w_now ? ref_ill(op1, b1) : ref_ill(op0, b0);
          to_ack <= 2;
          e_busy <= 1'b1;
        end else begin
          e_busy <= 1'b0;
        end
      end else if (to_ack == 2) begin
        to_ack <= 1;
        e_busy <= 1'b1;
      end else begin
        to_ack <= 0;
        e_busy <= 1'b0;
        if (m_who) begin e_ack1 <= 1'b1; e_res1 <= m_res; end
        else       begin e_ack0 <= 1'b1; e_res0 <= m_res; end
        e_err  <= m_err;
        m_last <= m_who;
`ifdef ALU_REQ_ARBITER_OPCNT_EN
        e_cnt  <= e_cnt + 8'd1;
`endif
      end
    end
  end

  logic [32:0] obs_v, exp_v;
  assign obs_v = {ack0, ack1, err, busy, res0, res1, ctrl, A, B, op_count};
  assign exp_v = {e_ack0, e_ack1, e_err, e_busy, e_res0, e_res1, e_ctrl, e_A, e_B, e_cnt};

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    checks++;
    if ({ack0, ack1, err, busy} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {ack0, ack1, err, busy});
    end
    checks++;
    if ({res0, res1} !== 12'h000) begin
      errors++; $display("FAIL reset_res got %h/%h want 0/0", res0, res1);
    end
    checks++;
    if ({ctrl, A, B} !== 9'h000) begin
      errors++; $display("FAIL reset_issue got %h/%h/%h want 0/0/0", ctrl, A, B);
    end
    checks++;
    if (op_count !== 8'd0) begin
      errors++; $display("FAIL reset_opcount got %0d want 0", op_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int ack_at, acks, busy_n, other;
    logic [5:0] r;
    logic e;
    logic [8:0] iss;
    ack_at = -1; acks = 0; busy_n = 0; other = 0; r = '0; e = 1'b0; iss = '0;
    req0 = 1'b1; op0 = 3'd0; a0 = 3'd5; b0 = 3'd6;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 1) iss = {ctrl, A, B};
      if (busy) busy_n++;
      if (ack1) other++;
      if (ack0) begin
        acks++;
        if (ack_at < 0) begin ack_at = k; r = res0; e = err; end
        req0 = 1'b0;
      end
    end
    checks++;
    if (ack_at != 3) begin errors++; $display("FAIL single_latency got %0d want 3", ack_at); end
    checks++;
    if (acks != 1 || other != 0) begin
      errors++; $display("FAIL single_ackcount got ack0=%0d ack1=%0d want 1/0", acks, other);
    end
    checks++;
    if (r !== 6'd11) begin errors++; $display("FAIL single_res got %0d want 11", r); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", e); end
    checks++;
    if (busy_n != 2) begin errors++; $display("FAIL single_busy got %0d want 2", busy_n); end
    checks++;
    if (iss !== {3'd0, 3'd5, 3'd6}) begin
      errors++; $display("FAIL single_issue got %h want %h", iss, {3'd0, 3'd5, 3'd6});
    end
  endtask

  task automatic test_contention();
    int who[$];
    int at[$];
    logic [5:0] rv[$];
    rst = 1'b1;
    op0 = 3'd2; a0 = 3'd7; b0 = 3'd7;
    op1 = 3'd1; a1 = 3'd3; b1 = 3'd1;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (ack0 || ack1) begin
        who.push_back(ack1 ? 1 : 0);
        at.push_back(k);
        rv.push_back(ack1 ? res1 : res0);
        if (who.size() == 4) begin
          req0 = 1'b0; req1 = 1'b0;
          break;
        end
      end
    end
    checks++;
    if (who.size() != 4) begin
      errors++; $display("FAIL contention_timeout got %0d acks want 4", who.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (who[i] != i % 2) begin
          errors++; $display("FAIL contention_order[%0d] got %0d want %0d", i, who[i], i % 2);
        end
        checks++;
        if (rv[i] !== ((i % 2) ? 6'd2 : 6'd49)) begin
          errors++; $display("FAIL contention_res[%0d] got %0d want %0d", i, rv[i], (i % 2) ? 2 : 49);
        end
        checks++;
        if (at[i] != 3 + 3 * i) begin
          errors++; $display("FAIL contention_time[%0d] got %0d want %0d", i, at[i], 3 + 3 * i);
        end
      end
    end
    tick(); tick();
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      logic got, e;
      logic [5:0] r;
      got = 1'b0; e = 1'b0; r = 6'h3F;
      if (i == 0) begin req1 = 1'b1; op1 = 3'd3; a1 = 3'd5; b1 = 3'd0; end
      else        begin req0 = 1'b1; op0 = 3'd6; a0 = 3'd2; b0 = 3'd3; end
      for (int k = 0; k < 8 && !got; k++) begin
        tick();
        if (i == 0 && ack1) begin got = 1'b1; e = err; r = res1; req1 = 1'b0; end
        if (i == 1 && ack0) begin got = 1'b1; e = err; r = res0; req0 = 1'b0; end
      end
      checks++;
      if (!got) begin errors++; $display("FAIL illegal%0d_noack got none want ack", i); end
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL illegal%0d_err got %b want 1", i, e); end
      checks++;
      if (r !== 6'd0) begin errors++; $display("FAIL illegal%0d_res got %0d want 0", i, r); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    int ack_at;
    logic [5:0] r;
    ack_at = -1; r = '0;
    req0 = 1'b1; op0 = 3'd2; a0 = 3'd3; b0 = 3'd5;
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL midrst_exec got busy=%b want 1", busy); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({ack0, busy, res0} !== 8'h00) begin
      errors++; $display("FAIL midrst_abort got ack0=%b busy=%b res0=%0d want 0/0/0", ack0, busy, res0);
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (ack0 && ack_at < 0) begin ack_at = k; r = res0; req0 = 1'b0; end
    end
    checks++;
    if (ack_at != 3) begin errors++; $display("FAIL midrst_latency got %0d want 3", ack_at); end
    checks++;
    if (r !== 6'd15) begin errors++; $display("FAIL midrst_res got %0d want 15", r); end
  endtask

  task automatic test_random();
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL random cyc %0d got %h want %h", c, obs_v, exp_v);
      end
      rst = ($urandom_range(0, 149) == 0);
      if (req0 && ack0) begin
        if ($urandom_range(0, 1) == 0) req0 = 1'b0;
        else {op0, a0, b0} = rand_any();
      end else if (!req0) begin
        if ($urandom_range(0, 2) == 0) begin req0 = 1'b1; {op0, a0, b0} = rand_any(); end
      end else if ($urandom_range(0, 7) == 0) begin
        {op0, a0, b0} = rand_any();
      end
      if (req1 && ack1) begin
        if ($urandom_range(0, 1) == 0) req1 = 1'b0;
        else {op1, a1, b1} = rand_any();
      end else if (!req1) begin
        if ($urandom_range(0, 2) == 0) begin req1 = 1'b1; {op1, a1, b1} = rand_any(); end
      end else if ($urandom_range(0, 7) == 0) begin
        {op1, a1, b1} = rand_any();
      end
    end
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick(); tick();
  endtask

  task automatic test_counter();
    int acks;
    logic [7:0] mid_want;
`ifdef ALU_REQ_ARBITER_OPCNT_EN
    mid_want = 8'd128;
`else
    mid_want = 8'd0;
`endif
    acks = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    req0 = 1'b1; {op0, a0, b0} = rand_legal();
    req1 = 1'b1; {op1, a1, b1} = rand_legal();
    for (int c = 0; c < 1000 && acks < 256; c++) begin
      tick();
      checks++;
      if (obs_v !== exp_v) begin
        errors++; $display("FAIL counter cyc %0d got %h want %h", c, obs_v, exp_v);
      end
      if (ack0 || ack1) begin
        acks++;
        if (acks == 128) begin
          checks++;
          if (op_count !== mid_want) begin
            errors++; $display("FAIL counter_mid got %0d want %0d", op_count, mid_want);
          end
        end
      end
      if (ack0) {op0, a0, b0} = rand_legal();
      if (ack1) {op1, a1, b1} = rand_legal();
      if (acks == 256) begin req0 = 1'b0; req1 = 1'b0; end
    end
    checks++;
    if (acks != 256) begin errors++; $display("FAIL counter_timeout got %0d acks want 256", acks); end
    tick(); tick(); tick();
    checks++;
    if (op_count !== 8'd0) begin errors++; $display("FAIL counter_wrap got %0d want 0", op_count); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL counter_idle got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_illegal();
    test_reset_mid();
    test_random();
    test_counter();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req0  input  1  requester 0 operation request, level, held until ack0.
REQ-005 op0  input  3  requester 0 opcode: 0 ADD, 1 MIN, 2 MULT, 3 DIV, 4 MOD.
REQ-006 a0, b0  input  3 each  requester 0 operands.
REQ-007 ack0  output  1  one-cycle completion pulse to requester 0.
REQ-008 res0  output  6  requester 0 result, valid with ack0, held until the next ack0.
REQ-009 req1, op1, a1, b1, ack1, res1: same as REQ-004..REQ-008, for requester 1.
REQ-010 ctrl  output  3  opcode driven to the shared ALU.
REQ-011 A, B  output  3 each  operands driven to the shared ALU.
REQ-012 Leds  input  6  shared ALU result.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  pulses with ack0 or ack1 when the served operation is illegal.
REQ-015 op_count  output  8  completed-operation counter (see Configuration).

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-017 IDLE: if req0 or req1 is high, SHALL pick a winner, register its op/a/b into ctrl/A/B, record the grant, and go to EXEC; otherwise SHALL stay in IDLE.
REQ-018 Arbitration SHALL be round-robin:
- if one request is high, it wins;
- if both are high, the requester not served last wins;
- the last-served pointer resets to requester 1, so requester 0 wins the first tie.
REQ-019 EXEC: SHALL hold ctrl/A/B for one settle cycle, then go to DONE.
REQ-020 DONE: SHALL register the result into the granted requester's res, pulse its ack for exactly one cycle, update the last-served pointer, and return to IDLE.
REQ-021 Latency SHALL be fixed: a request sampled in IDLE at edge N gives ack high in the cycle after edge N+2; back-to-back service period is 3 cycles.
REQ-022 The non-granted requester's ack and res SHALL not change during another requester's operation.
REQ-023 Illegal operation: op in 5..7, or op 3/4 with B=0.
- err SHALL pulse with the ack;
- the captured res SHALL be forced to 0 instead of Leds.
REQ-024 A legal operation SHALL give res = Leds zero-extended as sampled in DONE, with err low.
REQ-025 ctrl/A/B SHALL hold their last issued values while in IDLE.
REQ-026 Operand changes on a granted requester's inputs after the grant SHALL not affect the operation in flight.
REQ-027 A request still high in the IDLE cycle after its ack SHALL be treated as a new request.

Reset
REQ-028 When rst is high at a clock edge, all of the following SHALL hold at that edge:
- state = IDLE;
- ctrl, A, B = 0;
- ack0, ack1, err, busy = 0;
- res0, res1 = 0;
- last-served pointer = requester 1;
- op_count = 0.
REQ-029 Reset during EXEC or DONE SHALL abort the operation with no ack; a request still held is served normally after reset is released.

Configuration
REQ-030 Macro ALU_REQ_ARBITER_OPCNT_EN, when defined, SHALL make op_count increment by 1 on every ack0/ack1 pulse, including illegal operations, wrapping 255 -> 0.
REQ-031 When ALU_REQ_ARBITER_OPCNT_EN is undefined, op_count SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-032 Single request: req0=1, op0=0, a0=5, b0=6, ALU model -> ack0 pulses 3 cycles after the request edge; res0=11; err=0; busy high for 2 cycles.
REQ-033 Contention: req0 and req1 held high from reset release with op0=2 (a0=7, b0=7) and op1=1 (a1=3, b1=1) -> order is 0, 1, 0, 1; res0=49, res1=2; acks 3 cycles apart.
REQ-034 Illegal operations:
- op1=3, b1=0 -> ack1 with err=1 and res1=0;
- op0=6 -> ack0 with err=1 and res0=0.
REQ-035 Reset mid-operation: assert rst in EXEC with req0 held -> no ack0; after release, ack0 arrives 3 cycles later with the correct result.
REQ-036 Counter: with the macro defined, 256 legal operations -> op_count wraps to 0; without the macro, op_count stays 0 throughout.
